// File: rtl/pe_v3_pkg.sv
// pe_v3_pkg: opcode/func constants, FSM state and FIFO entry for pe_core_v3.
// Entry result field is PE_MAX_DW wide; cores use the low DATA_WIDTH bits.
package pe_v3_pkg;

  localparam int PE_MAX_DW = 64;

  localparam logic [6:0] OP_ARITH = 7'b0000001;
  localparam logic [6:0] OP_FPU   = 7'b0000010;
  localparam logic [6:0] OP_COMP  = 7'b0010000;

  localparam logic [4:0] A_ADD = 5'd1;
  localparam logic [4:0] A_SUB = 5'd2;
  localparam logic [4:0] A_MUL = 5'd3;
  localparam logic [4:0] A_DIV = 5'd4;
  localparam logic [4:0] A_MAD = 5'd5;
  localparam logic [4:0] A_REM = 5'd6;
  localparam logic [4:0] A_AND = 5'd9;
  localparam logic [4:0] A_OR  = 5'd10;
  localparam logic [4:0] A_XOR = 5'd11;
  localparam logic [4:0] A_SHL = 5'd12;
  localparam logic [4:0] A_SHR = 5'd13;

  localparam logic [4:0] F_FMA  = 5'd1;
  localparam logic [4:0] F_RELU = 5'd11;
  localparam logic [4:0] F_ABS  = 5'd13;
  localparam logic [4:0] F_NEG  = 5'd14;
  localparam logic [4:0] F_MIN  = 5'd16;
  localparam logic [4:0] F_MAX  = 5'd17;

  localparam logic [4:0] C_EQ = 5'd1;
  localparam logic [4:0] C_NE = 5'd2;
  localparam logic [4:0] C_LT = 5'd3;
  localparam logic [4:0] C_LE = 5'd4;
  localparam logic [4:0] C_GT = 5'd5;
  localparam logic [4:0] C_GE = 5'd6;

  typedef enum logic {IDLE, DIV_BUSY} state_t;

  typedef struct packed {
    logic [PE_MAX_DW-1:0] result;
    logic [4:0]           rd;
    logic                 err;
  } fifo_entry_t;

endpackage

// File: rtl/pe_v3_divider.sv
// pe_v3_divider: unsigned restoring divider, one quotient bit per cycle.
// Ports: clk, rst_n, start, dividend, divisor -> busy, done (1-cycle pulse),
// quotient, remainder (valid while done is high and until next start).
module pe_v3_divider
  import pe_v3_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder
);

  localparam int DW  = DATA_WIDTH;
  localparam int CNW = $clog2(DATA_WIDTH + 1);

  logic [DW-1:0]  r_quo;
  logic [DW-1:0]  r_rem;
  logic [DW-1:0]  r_dvs;
  logic [CNW-1:0] r_cnt;
  logic           r_busy;
  logic           r_done;
  logic [DW:0]    w_sh;
  logic [DW:0]    w_sub;

  // Partial remainder shifted left with the next dividend bit;
  // a clear borrow bit means the divisor fits.
  assign w_sh  = {r_rem, r_quo[DW-1]};
  assign w_sub = w_sh - {1'b0, r_dvs};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_quo  <= dividend;
        r_rem  <= '0;
        r_dvs  <= divisor;
        r_cnt  <= CNW'(DATA_WIDTH);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        if (!w_sub[DW]) begin
          r_rem <= w_sub[DW-1:0];
          r_quo <= {r_quo[DW-2:0], 1'b1};
        end else begin
          r_rem <= w_sh[DW-1:0];
          r_quo <= {r_quo[DW-2:0], 1'b0};
        end
        r_cnt <= r_cnt - CNW'(1);
        if (r_cnt == CNW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_quo;
  assign remainder = r_rem;

endmodule

// File: rtl/pe_core_v3.sv
// pe_core_v3: PE core with execute register, iterative divider, result FIFO.
// In: clk, rst_n, instr, valid_in, op1_i..op3_i, result_ready.
// Out: ready_out, result_o, rd_o, err_o, result_valid.
// Define PE_V3_DIV_EN to build the divider; otherwise DIV/REM are illegal.
module pe_core_v3
  import pe_v3_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           instr,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [DATA_WIDTH-1:0] op1_i,
  input  logic [DATA_WIDTH-1:0] op2_i,
  input  logic [DATA_WIDTH-1:0] op3_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [4:0]            rd_o,
  output logic                  err_o,
  output logic                  result_valid,
  input  logic                  result_ready
);

  localparam int DW  = DATA_WIDTH;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int OW  = CW + 1;
  localparam int SHW = $clog2(DATA_WIDTH);

  logic [6:0]    w_opc;
  logic [4:0]    w_fn;
  logic [4:0]    w_rd;
  logic          w_acc;
  logic          w_is_div;
  logic          w_start;

  state_t        r_state;
  logic [4:0]    r_div_rd;
  logic          r_div_rem;

  logic          r_e_valid;
  logic [6:0]    r_e_opc;
  logic [4:0]    r_e_fn;
  logic [4:0]    r_e_rd;
  logic [DW-1:0] r_e_op1;
  logic [DW-1:0] r_e_op2;
  logic [DW-1:0] r_e_op3;

  logic [DW-1:0] w_res;
  logic          w_err;
  logic [DW-1:0] w_mul;
  logic          w_lt;
  logic          w_eq;

  logic          w_dv_busy;
  logic          w_dv_done;
  logic [DW-1:0] w_dv_q;
  logic [DW-1:0] w_dv_r;

  fifo_entry_t   r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [OW-1:0] w_occ;
  fifo_entry_t   w_push_e;
  fifo_entry_t   w_head;
  logic          w_push;
  logic          w_pop;
  logic          w_unused;

  assign w_opc = instr[31:25];
  assign w_fn  = instr[24:20];
  assign w_rd  = instr[19:15];
  assign w_acc = valid_in && ready_out;

`ifdef PE_V3_DIV_EN
  // Zero divisors stay on the single-cycle path.
  assign w_is_div = (w_opc == OP_ARITH) &&
                    ((w_fn == A_DIV) || (w_fn == A_REM)) &&
                    (op2_i != '0);

  pe_v3_divider #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_start),
    .dividend (op1_i),
    .divisor  (op2_i),
    .busy     (w_dv_busy),
    .done     (w_dv_done),
    .quotient (w_dv_q),
    .remainder(w_dv_r)
  );
`else
  assign w_is_div  = 1'b0;
  assign w_dv_busy = 1'b0;
  assign w_dv_done = 1'b0;
  assign w_dv_q    = '0;
  assign w_dv_r    = '0;
`endif

  assign w_start = w_acc && w_is_div;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_div_rd  <= '0;
      r_div_rem <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state   <= DIV_BUSY;
            r_div_rd  <= w_rd;
            r_div_rem <= (w_fn == A_REM);
          end
        end
        DIV_BUSY: begin
          if (w_dv_done) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e_valid <= 1'b0;
      r_e_opc   <= '0;
      r_e_fn    <= '0;
      r_e_rd    <= '0;
      r_e_op1   <= '0;
      r_e_op2   <= '0;
      r_e_op3   <= '0;
    end else begin
      r_e_valid <= w_acc && !w_is_div;
      if (w_acc && !w_is_div) begin
        r_e_opc <= w_opc;
        r_e_fn  <= w_fn;
        r_e_rd  <= w_rd;
        r_e_op1 <= op1_i;
        r_e_op2 <= op2_i;
        r_e_op3 <= op3_i;
      end
    end
  end

  assign w_mul = r_e_op1 * r_e_op2;
  assign w_lt  = $signed(r_e_op1) < $signed(r_e_op2);
  assign w_eq  = (r_e_op1 == r_e_op2);

  always_comb begin
    w_res = '0;
    w_err = 1'b0;
    unique case (1'b1)
      (r_e_opc == OP_ARITH): begin
        case (r_e_fn)
          A_ADD: w_res = r_e_op1 + r_e_op2;
          A_SUB: w_res = r_e_op1 - r_e_op2;
          A_MUL: w_res = w_mul;
          A_MAD: w_res = w_mul + r_e_op3;
`ifdef PE_V3_DIV_EN
          A_DIV: begin
            w_res = '1;
            w_err = 1'b1;
          end
          A_REM: begin
            w_res = r_e_op1;
            w_err = 1'b1;
          end
`endif
          A_AND: w_res = r_e_op1 & r_e_op2;
          A_OR:  w_res = r_e_op1 | r_e_op2;
          A_XOR: w_res = r_e_op1 ^ r_e_op2;
          A_SHL: w_res = r_e_op1 << r_e_op2[SHW-1:0];
          A_SHR: w_res = r_e_op1 >> r_e_op2[SHW-1:0];
          default: w_err = 1'b1;
        endcase
      end
      (r_e_opc == OP_FPU): begin
        case (r_e_fn)
          F_FMA:  w_res = w_mul + r_e_op3;
          F_RELU: w_res = r_e_op1[DW-1] ? '0 : r_e_op1;
          F_ABS:  w_res = r_e_op1[DW-1] ? -r_e_op1 : r_e_op1;
          F_NEG:  w_res = -r_e_op1;
          F_MIN:  w_res = w_lt ? r_e_op1 : r_e_op2;
          F_MAX:  w_res = w_lt ? r_e_op2 : r_e_op1;
          default: w_err = 1'b1;
        endcase
      end
      (r_e_opc == OP_COMP): begin
        case (r_e_fn)
          C_EQ: w_res = {{(DW-1){1'b0}}, w_eq};
          C_NE: w_res = {{(DW-1){1'b0}}, !w_eq};
          C_LT: w_res = {{(DW-1){1'b0}}, w_lt};
          C_LE: w_res = {{(DW-1){1'b0}}, w_lt || w_eq};
          C_GT: w_res = {{(DW-1){1'b0}}, !(w_lt || w_eq)};
          C_GE: w_res = {{(DW-1){1'b0}}, !w_lt};
          default: w_err = 1'b1;
        endcase
      end
      default: w_err = 1'b1;
    endcase
  end

  // E and divider never complete on the same edge: no issue while busy.
  assign w_push = r_e_valid || w_dv_done;
  assign w_pop  = (r_count != '0) && result_ready;

  always_comb begin
    w_push_e = '0;
    if (w_dv_done) begin
      w_push_e.result = PE_MAX_DW'(r_div_rem ? w_dv_r : w_dv_q);
      w_push_e.rd     = r_div_rd;
      w_push_e.err    = 1'b0;
    end else begin
      w_push_e.result = PE_MAX_DW'(w_res);
      w_push_e.rd     = r_e_rd;
      w_push_e.err    = w_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_push_e;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // E counts as a reserved slot so its push can never overflow.
  assign w_occ     = {1'b0, r_count} + {{CW{1'b0}}, r_e_valid};
  assign ready_out = (r_state == IDLE) && (w_occ < OW'(FIFO_DEPTH));

  assign w_head       = r_mem[r_rptr];
  assign result_o     = w_head.result[DW-1:0];
  assign rd_o         = w_head.rd;
  assign err_o        = w_head.err;
  assign result_valid = (r_count != '0);

  assign w_unused = ^{instr[14:0], w_head.result, w_dv_busy};

endmodule
